// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared FSM encodings, mode codes and frame field positions for the I2S sample controller
package i2s_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_PUSH_R = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SYNC   = ST_SYNC,
        RUN    = ST_RUN,
        PUSH_R = ST_PUSH_R
    } state_e;

    localparam logic [1:0] MODE_LEFT   = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_STEREO = 2'b10;

    localparam int LEFT_MSB  = 63;
    localparam int LEFT_LSB  = 32;
    localparam int RIGHT_MSB = 31;
    localparam int RIGHT_LSB = 0;
    localparam int SAMPLE_W  = 32;

endpackage

// File: rtl/i2s_rx_sample_ctrl_if.sv
// rtl/i2s_rx_sample_ctrl_if.sv - bus-side control and sample-read signals of the I2S sample controller
interface i2s_rx_sample_ctrl_if #(
    parameter int LVL_W = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [LVL_W-1:0] thresh;
    logic             flush;
    logic             clr_ovf;
    logic             pop;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             irq;

    modport master (
        output en, mode, thresh, flush, clr_ovf, pop,
        input  rd_data, rd_valid, level, overflow, irq
    );

    modport slave (
        input  en, mode, thresh, flush, clr_ovf, pop,
        output rd_data, rd_valid, level, overflow, irq
    );
endinterface

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - synchronous first-word-fall-through sample FIFO with flush and level output
module i2s_sample_fifo
    import i2s_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] push_data,
    input  logic                pop,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                empty,
    output logic                full,
    output logic [LVL_W-1:0]    level,
    output logic [LVL_W-1:0]    level_next
);
    localparam int AW = LVL_W - 1;

    logic [LVL_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];
    logic                do_push;
    logic                do_pop;

    // The extra pointer bit tells full from empty, so level is a plain subtraction.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == LVL_W'(DEPTH));

    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + LVL_W'(do_push);
        rd_ptr_d = rd_ptr_q + LVL_W'(do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
    end

    assign level_next = wr_ptr_d - rd_ptr_d;
    assign rd_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/i2s_rx_sample_ctrl.sv
// rtl/i2s_rx_sample_ctrl.sv - I2S receive sequencer: ws frame detect, partial-frame discard, word select, FIFO
// Optional statistics counters (frame_cnt, drop_cnt) under I2S_RX_SAMPLE_CTRL_STATS_EN.
module i2s_rx_sample_ctrl
    import i2s_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        ws_i,
    input  logic [63:0] rx_data_i,
    i2s_rx_sample_ctrl_if.slave bus
`ifdef I2S_RX_SAMPLE_CTRL_STATS_EN
    ,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);
    logic                ws_q, ws_d;
    logic [1:0]          state_q, state_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                overflow_q, overflow_d;
    logic                irq_q, irq_d;

    logic                frame_evt;
    logic                push;
    logic [SAMPLE_W-1:0] push_data;
    logic                drop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [LVL_W-1:0]    level_next;

    assign ws_d      = ws_i;
    assign frame_evt = ws_i & ~ws_q;

    always_comb begin
        state_d   = state_q;
        right_d   = right_q;
        push      = 1'b0;
        push_data = '0;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: if (frame_evt) state_d = ST_RUN;
                ST_RUN: begin
                    if (frame_evt) begin
                        push = 1'b1;
                        if (bus.mode == MODE_STEREO) begin
                            push_data = rx_data_i[LEFT_MSB:LEFT_LSB];
                            right_d   = rx_data_i[RIGHT_MSB:RIGHT_LSB];
                            state_d   = ST_PUSH_R;
                        end else if (bus.mode == MODE_RIGHT) begin
                            push_data = rx_data_i[RIGHT_MSB:RIGHT_LSB];
                        end else begin
                            push_data = rx_data_i[LEFT_MSB:LEFT_LSB];
                        end
                    end
                end
                ST_PUSH_R: begin
                    push      = 1'b1;
                    push_data = right_q;
                    state_d   = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A full FIFO accepts a push only when the same cycle also pops it.
    assign drop = push & ~bus.flush & fifo_full & ~bus.pop;

    always_comb begin
        overflow_d = overflow_q;
        if (bus.clr_ovf) overflow_d = 1'b0;
        if (drop)        overflow_d = 1'b1;
        irq_d = (bus.thresh != '0) && (level_next >= bus.thresh);
    end

    i2s_sample_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk        (HCLK),
        .rst        (HRESET),
        .flush      (bus.flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (bus.pop),
        .rd_data    (bus.rd_data),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (bus.level),
        .level_next (level_next)
    );

    assign bus.rd_valid = ~fifo_empty;
    assign bus.overflow = overflow_q;
    assign bus.irq      = irq_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ws_q       <= 1'b0;
            state_q    <= ST_IDLE;
            right_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ws_q       <= ws_d;
            state_q    <= state_d;
            right_q    <= right_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

`ifdef I2S_RX_SAMPLE_CTRL_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (bus.en && (state_q == ST_RUN) && frame_evt) frame_cnt_d = frame_cnt_q + 32'd1;
        if (drop && (drop_cnt_q != 16'hFFFF))           drop_cnt_d  = drop_cnt_q + 16'd1;
        if (bus.flush) begin
            frame_cnt_d = '0;
            drop_cnt_d  = '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
